// File: rtl/sram_tile_reader_if.sv
// Bus bundle for the tile reader: SRAM read pins plus the 8-bit pixel stream.
// The master side is the reader; the slave side is the SRAM and the encoder.
interface sram_tile_reader_if;
  logic [17:0] address_to_sram;
  logic [31:0] data_sram;
  logic        write_en_n;
  logic        chip_en;
  logic        output_en;
  logic        adv;
  logic [3:0]  byte_en;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;

  modport master (
    output address_to_sram, write_en_n, chip_en, output_en, adv, byte_en,
    output pix_data, pix_valid, pix_last,
    input  data_sram, pix_ready
  );

  modport slave (
    input  address_to_sram, write_en_n, chip_en, output_en, adv, byte_en,
    input  pix_data, pix_valid, pix_last,
    output data_sram, pix_ready
  );
endinterface

// File: rtl/sram_tile_reader.sv
// Reads one tile from the 32-bit frame SRAM and streams it as bytes, MSB first.
// Reads are throttled so in-flight reads plus buffered words never exceed the FIFO depth.
module sram_tile_reader #(
  parameter int unsigned IMG_W_WORDS  = 160,
  parameter int unsigned TILE_W_WORDS = 32,
  parameter int unsigned TILE_H       = 128,
  parameter int unsigned SRAM_LAT     = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                clk_100,
  input  logic                rst,
  input  logic                start_i,
  input  logic [17:0]         tile_base_addr_i,
  output logic                tile_done_o,
  output logic                busy_o,
  sram_tile_reader_if.master  bus_io
);

  localparam int unsigned ColW       = (TILE_W_WORDS > 1) ? $clog2(TILE_W_WORDS) : 1;
  localparam int unsigned RowW       = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int unsigned TotalWords = TILE_W_WORDS * TILE_H;
  localparam int unsigned PopW       = (TotalWords > 1) ? $clog2(TotalWords) : 1;
  localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);

  localparam logic [ColW-1:0] ColLast = ColW'(TILE_W_WORDS - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(TILE_H - 1);
  localparam logic [PopW-1:0] PopLast = PopW'(TotalWords - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [17:0]         addr_q, addr_d, row_base_q, row_base_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [SRAM_LAT-1:0] vld_q, vld_d;
  logic [SRAM_LAT:0]   vld_shift;
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          byte_q, byte_d;
  logic [PopW-1:0]     pop_cnt_q, pop_cnt_d;
  logic                done_q;

  logic        issue, push, pop, hs, room, last_issued, pix_valid, pix_last, final_hs;
  logic [31:0] head;
  logic [7:0]  pix_byte;
  int unsigned occ;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Outstanding reads are counted as well as buffered words, so a push always has a free slot.
  always_comb begin
    occ = 32'(cnt_q);
    for (int i = 0; i < SRAM_LAT; i++) occ += 32'(vld_q[i]);
    room = occ < FIFO_DEPTH;
  end

  assign last_issued = (row_q == RowLast) && (col_q == ColLast);
  assign push        = vld_q[SRAM_LAT-1];
  assign vld_shift   = {vld_q, issue};
  assign vld_d       = vld_shift[SRAM_LAT-1:0];

  assign pix_valid = (cnt_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign hs        = pix_valid && bus_io.pix_ready;
  assign pop       = hs && (byte_q == 2'd3);
  assign pix_last  = pix_valid && (byte_q == 2'd3) && (pop_cnt_q == PopLast);
  assign final_hs  = hs && pix_last;

  always_comb begin
    pix_byte = 8'h00;
    if (pix_valid) begin
      unique case (byte_q)
        2'd0: pix_byte = head[31:24];
        2'd1: pix_byte = head[23:16];
        2'd2: pix_byte = head[15:8];
        2'd3: pix_byte = head[7:0];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    issue      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          issue      = 1'b1;
          addr_d     = tile_base_addr_i;
          row_base_d = tile_base_addr_i;
          col_d      = '0;
          row_d      = '0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (last_issued) begin
          state_d = StDrain;
        end else if (room) begin
          issue = 1'b1;
          if (col_q == ColLast) begin
            addr_d     = row_base_q + 18'(IMG_W_WORDS);
            row_base_d = row_base_q + 18'(IMG_W_WORDS);
            col_d      = '0;
            row_d      = row_q + RowW'(1);
          end else begin
            addr_d = addr_q + 18'd1;
            col_d  = col_q + ColW'(1);
          end
        end
      end
      StDrain: ;
      default: state_d = StIdle;
    endcase
    if (final_hs) state_d = StIdle;
  end

  always_comb begin
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    byte_d    = hs ? byte_q + 2'd1 : byte_q;
    pop_cnt_d = final_hs ? '0 : (pop ? pop_cnt_q + PopW'(1) : pop_cnt_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      byte_q     <= '0;
      pop_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      pop_cnt_q  <= pop_cnt_d;
      done_q     <= final_hs;
    end
  end

  // Storage needs no reset: every read is gated by the occupancy count.
  always_ff @(posedge clk_100) begin
    if (push) mem_q[wr_ptr_q] <= bus_io.data_sram;
  end

  assign busy_o                 = (state_q != StIdle);
  assign tile_done_o            = done_q;
  assign bus_io.address_to_sram = addr_q;
  assign bus_io.write_en_n      = 1'b1;
  assign bus_io.chip_en         = ~busy_o;
  assign bus_io.output_en       = ~busy_o;
  assign bus_io.adv             = 1'b0;
  assign bus_io.byte_en         = 4'b0000;
  assign bus_io.pix_data        = pix_byte;
  assign bus_io.pix_valid       = pix_valid;
  assign bus_io.pix_last        = pix_last;

endmodule

// File: tb/tb_sram_tile_reader.sv
// Table-driven bench for sram_tile_reader on a small tile geometry, with a pixel scoreboard,
// an address log and hand-written latency, wrap and mid-tile reset sequences.
module tb_sram_tile_reader;
  localparam int unsigned IMG  = 10;
  localparam int unsigned TW   = 4;
  localparam int unsigned TH   = 3;
  localparam int unsigned NPIX = TW * TH * 4;

  typedef struct packed {
    logic [17:0] base;
    int          pct;
    int          glitch;
    logic [7:0]  first_pix;
  } vec_t;

  logic        clk_100 = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] base_in;
  logic        tile_done;
  logic        busy;
  logic [17:0] a1;

  sram_tile_reader_if bus ();

  sram_tile_reader #(
    .IMG_W_WORDS (IMG),
    .TILE_W_WORDS(TW),
    .TILE_H      (TH),
    .SRAM_LAT    (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_100         (clk_100),
    .rst             (rst),
    .start_i         (start),
    .tile_base_addr_i(base_in),
    .tile_done_o     (tile_done),
    .busy_o          (busy),
    .bus_io          (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pct = 100;
  int hs_cnt, first_hs, last_hs, done_cnt;
  bit mon_en = 0;
  bit log_en = 0;
  bit have_prev;
  bit stall_q = 0;
  logic [7:0]  stall_data;
  logic [17:0] prev_addr;
  logic [7:0]  exp_q[$];
  logic [17:0] exp_addr_q[$];
  logic [17:0] addr_log[$];
  vec_t vecs[5];

  initial forever #5 clk_100 = ~clk_100;
  initial forever begin
    @(posedge clk_100);
    cyc++;
  end

  function automatic logic [31:0] word_of(input logic [17:0] a);
    return {a[7:0] ^ 8'hA1, a[15:8] ^ 8'hB2, {6'b0, a[17:16]} ^ 8'hC3, a[7:0] ^ 8'hD4};
  endfunction

  // SRAM model: data for the address seen at one edge is on the bus until the next.
  initial forever begin
    @(posedge clk_100);
    a1 <= bus.address_to_sram;
  end
  assign bus.data_sram = word_of(a1);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Pixel monitor: decides pix_ready, then scores the handshake due at the next edge.
  initial forever begin
    @(negedge clk_100);
    if (mon_en) begin
      if (stall_q) begin
        check("stall_valid", 32'(bus.pix_valid), 1);
        check("stall_data", 32'(bus.pix_data), 32'(stall_data));
      end
      if (tile_done) begin
        done_cnt++;
        check("done_empty", exp_q.size(), 0);
        check("done_busy", 32'(busy), 0);
      end
      bus.pix_ready = ($urandom_range(99) < pct);
      if (bus.pix_valid) check("pix_last", 32'(bus.pix_last), 32'(exp_q.size() == 1));
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pix_extra: got pixel %0h, required none", bus.pix_data);
        end else begin
          check("pix_data", 32'(bus.pix_data), 32'(exp_q.pop_front()));
        end
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
      stall_q    = bus.pix_valid && !bus.pix_ready;
      stall_data = bus.pix_data;
    end else begin
      stall_q       = 0;
      bus.pix_ready = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk_100);
    if (log_en && busy && (!have_prev || bus.address_to_sram != prev_addr)) begin
      addr_log.push_back(bus.address_to_sram);
      prev_addr = bus.address_to_sram;
      have_prev = 1;
    end
  end

  task automatic load_expect(input logic [17:0] b);
    logic [17:0] a;
    logic [31:0] w;
    exp_q.delete();
    exp_addr_q.delete();
    addr_log.delete();
    have_prev = 0;
    hs_cnt    = 0;
    done_cnt  = 0;
    for (int r = 0; r < int'(TH); r++) begin
      for (int c = 0; c < int'(TW); c++) begin
        a = b + 18'(r * IMG + c);
        w = word_of(a);
        exp_addr_q.push_back(a);
        for (int k = 3; k >= 0; k--) exp_q.push_back(w[k*8 +: 8]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, 32'(bus.address_to_sram), 0);
    check({tag, "_ce"}, 32'(bus.chip_en), 1);
    check({tag, "_oe"}, 32'(bus.output_en), 1);
    check({tag, "_we"}, 32'(bus.write_en_n), 1);
    check({tag, "_adv"}, 32'(bus.adv), 0);
    check({tag, "_be"}, 32'(bus.byte_en), 0);
    check({tag, "_valid"}, 32'(bus.pix_valid), 0);
    check({tag, "_data"}, 32'(bus.pix_data), 0);
    check({tag, "_last"}, 32'(bus.pix_last), 0);
    check({tag, "_done"}, 32'(tile_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic run_tile(input vec_t v);
    int t;
    bit glitched;
    @(negedge clk_100);
    #1;
    load_expect(v.base);
    pct     = v.pct;
    mon_en  = 1;
    log_en  = 1;
    start   = 1'b1;
    base_in = v.base;
    @(negedge clk_100);
    #1;
    start   = 1'b0;
    base_in = ~v.base;
    check("start_busy", 32'(busy), 1);
    check("first_addr", 32'(bus.address_to_sram), 32'(v.base));
    @(negedge clk_100);
    #1;
    check("lat_valid_lo", 32'(bus.pix_valid), 0);
    @(negedge clk_100);
    #1;
    check("lat_valid_hi", 32'(bus.pix_valid), 1);
    check("first_pix", 32'(bus.pix_data), 32'(v.first_pix));
    t = 0;
    glitched = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(negedge clk_100);
      #1;
      t++;
      start = 1'b0;
      if (v.glitch >= 0 && !glitched && hs_cnt >= v.glitch) begin
        start    = 1'b1;
        base_in  = v.base ^ 18'h2A5A5;
        glitched = 1;
      end
    end
    start = 1'b0;
    check("tile_done_seen", done_cnt, 1);
    repeat (4) @(negedge clk_100);
    #1;
    check("done_once", done_cnt, 1);
    check("pix_count", hs_cnt, NPIX);
    check("queue_left", exp_q.size(), 0);
    check("end_busy", 32'(busy), 0);
    check("addr_count", addr_log.size(), exp_addr_q.size());
    for (int i = 0; i < addr_log.size() && i < exp_addr_q.size(); i++)
      check("addr_seq", 32'(addr_log[i]), 32'(exp_addr_q[i]));
    if (v.pct == 100) check("no_bubble", last_hs - first_hs + 1, NPIX);
    log_en = 0;
  endtask

  initial begin
    int t;
    vecs[0] = '{base: 18'h00000, pct: 100, glitch: -1, first_pix: 8'hA1};
    vecs[1] = '{base: 18'h3FFFE, pct: 100, glitch: -1, first_pix: 8'h5F};
    vecs[2] = '{base: 18'h00123, pct: 30,  glitch: -1, first_pix: 8'h82};
    vecs[3] = '{base: 18'h01005, pct: 30,  glitch: 20, first_pix: 8'hA4};
    vecs[4] = '{base: 18'h20000, pct: 70,  glitch: 7,  first_pix: 8'hA1};

    rst     = 1'b0;
    start   = 1'b0;
    base_in = '0;
    repeat (3) @(negedge clk_100);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_tile(vecs[i]);

    // Reset in the middle of a tile, then a clean tile from a new base.
    @(negedge clk_100);
    #1;
    load_expect(18'h00040);
    pct     = 100;
    mon_en  = 1;
    start   = 1'b1;
    base_in = 18'h00040;
    @(negedge clk_100);
    #1;
    start = 1'b0;
    t = 0;
    while (hs_cnt < 20 && t < 500) begin
      @(negedge clk_100);
      #1;
      t++;
    end
    check("rst_reach", 32'(hs_cnt >= 20), 1);
    rst    = 1'b0;
    mon_en = 0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk_100);
    #1;
    rst = 1'b1;
    exp_q.delete();
    run_tile('{base: 18'h00085, pct: 50, glitch: -1, first_pix: 8'h24});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
